jtag_scan_master: RTL

- Host-side JTAG driver: the initiating end of the TAP protocol.
- Takes IR-scan, DR-scan and reset commands on a valid/ready interface and generates the TMS/TDI sequence that walks a standard 16-state TAP controller through the scan.
- Collects TDO and returns it on a response handshake.
- Sits between test software/bench sequencers and the TAP plus its IR/DR chains, and tracks a mirror of the TAP state internally.

---
 rtl/jtag_scan_master.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/jtag_scan_master.sv
// jtag_scan_master: host-side JTAG driver that walks a TAP through
// IR/DR scans and resets, returning the captured TDO bits.
module jtag_scan_master #(
   parameter int MAX_LEN = 32,
   parameter int LEN_W   = 6
) (
   input  logic               TCLK,
   input  logic               TRSTN,
   input  logic               cmd_valid,
   output logic               cmd_ready,
   input  logic [1:0]         cmd_op,
   input  logic [LEN_W-1:0]   cmd_len,
   input  logic [MAX_LEN-1:0] cmd_data,
   output logic               rsp_valid,
   input  logic               rsp_ready,
   output logic [MAX_LEN-1:0] rsp_data,
   output logic               TMS,
   output logic               TDI,
   input  logic               TDO,
   output logic               busy
);

   localparam int CW = LEN_W + 1;

   typedef enum logic [3:0] {
      TLR   = 4'd0,  IDLE  = 4'd1,
      SELDR = 4'd2,  CAPDR = 4'd3,
      SHDR  = 4'd4,  EX1DR = 4'd5,
      PAUDR = 4'd6,  EX2DR = 4'd7,
      UPDR  = 4'd8,  SELIR = 4'd9,
      CAPIR = 4'd10, SHIR  = 4'd11,
      EX1IR = 4'd12, PAUIR = 4'd13,
      EX2IR = 4'd14, UPIR  = 4'd15
   } tap_t;

   typedef enum logic [2:0] {
      C_START, C_WAIT, C_IDLE, C_SCAN, C_RSP
   } ctl_t;

   tap_t               tap_q, tap_d;
   ctl_t               ctl_q, ctl_d;
   logic               ir_q, ir_d;
   logic               rs_q, rs_d;
   logic [CW-1:0]      len_q, len_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [CW-1:0]      tot, eff_len;
   logic [LEN_W-1:0]   rcnt_q, rcnt_d;
   logic [MAX_LEN-1:0] sreg_q, sreg_d;
   logic [MAX_LEN-1:0] rsp_q, rsp_d;
   logic               tms_q, tms_d;
   logic               tdi_q, tdi_d;
   logic               rv_q, rv_d;
   logic [1:0]         stk;

   function automatic tap_t tap_next(
      input tap_t s,
      input logic t
   );
      unique case (s)
         TLR:     return t ? TLR   : IDLE;
         IDLE:    return t ? SELDR : IDLE;
         SELDR:   return t ? SELIR : CAPDR;
         CAPDR:   return t ? EX1DR : SHDR;
         SHDR:    return t ? EX1DR : SHDR;
         EX1DR:   return t ? UPDR  : PAUDR;
         PAUDR:   return t ? EX2DR : PAUDR;
         EX2DR:   return t ? UPDR  : SHDR;
         UPDR:    return t ? SELDR : IDLE;
         SELIR:   return t ? TLR   : CAPIR;
         CAPIR:   return t ? EX1IR : SHIR;
         SHIR:    return t ? EX1IR : SHIR;
         EX1IR:   return t ? UPIR  : PAUIR;
         PAUIR:   return t ? EX2IR : PAUIR;
         EX2IR:   return t ? UPIR  : SHIR;
         default: return t ? SELDR : IDLE;
      endcase
   endfunction

   // {shift, tms} for step k of a command
   function automatic logic [1:0] step(
      input logic          ir,
      input logic          rs,
      input logic [CW-1:0] len,
      input logic [CW-1:0] k
   );
      logic [CW-1:0] pre;
      pre = ir ? CW'(4) : CW'(3);
      if (rs)
         return {1'b0, k < CW'(5)};
      else if (k < pre)
         return {1'b0, (k == '0) ||
                       (ir && k == CW'(1))};
      else if (k < pre + len)
         return {1'b1, k == pre + len - CW'(1)};
      else
         return {1'b0, k == pre + len};
   endfunction

   always_comb begin
      if (cmd_len == '0)
         eff_len = CW'(1);
      else if ({1'b0, cmd_len} > CW'(MAX_LEN))
         eff_len = CW'(MAX_LEN);
      else
         eff_len = {1'b0, cmd_len};
   end

   assign tot = rs_q ? CW'(6)
              : len_q + (ir_q ? CW'(6) : CW'(5));

   always_comb begin
      ctl_d  = ctl_q;
      ir_d   = ir_q;
      rs_d   = rs_q;
      len_d  = len_q;
      cnt_d  = cnt_q;
      rcnt_d = rcnt_q;
      sreg_d = sreg_q;
      rsp_d  = rsp_q;
      rv_d   = rv_q;
      tms_d  = 1'b0;
      tdi_d  = 1'b0;
      stk    = '0;
      tap_d  = tap_next(tap_q, tms_q);
      unique case (ctl_q)
         C_START: ctl_d = C_WAIT;
         C_WAIT:  ctl_d = C_IDLE;
         C_IDLE: begin
            if (cmd_valid) begin
               ir_d   = cmd_op == 2'd1;
               rs_d   = cmd_op[1];
               len_d  = eff_len;
               sreg_d = cmd_data;
               rsp_d  = '0;
               rcnt_d = '0;
               cnt_d  = CW'(1);
               stk    = step(cmd_op == 2'd1,
                             cmd_op[1],
                             eff_len, '0);
               tms_d  = stk[0];
               ctl_d  = C_SCAN;
            end
         end
         C_SCAN: begin
            // TAP consumes TDI bit i on this edge
            if (tap_q == SHDR || tap_q == SHIR) begin
               rsp_d  = rsp_q |
                  ({{(MAX_LEN-1){1'b0}}, TDO}
                   << rcnt_q);
               rcnt_d = rcnt_q + LEN_W'(1);
            end
            if (cnt_q == tot) begin
               rv_d  = 1'b1;
               ctl_d = C_RSP;
            end else begin
               stk   = step(ir_q, rs_q, len_q, cnt_q);
               tms_d = stk[0];
               if (stk[1]) begin
                  tdi_d  = sreg_q[0];
                  sreg_d = sreg_q >> 1;
               end
               cnt_d = cnt_q + CW'(1);
            end
         end
         C_RSP: begin
            if (rsp_ready) begin
               rv_d  = 1'b0;
               ctl_d = C_IDLE;
            end
         end
         default: ctl_d = C_START;
      endcase
   end

   always_ff @(posedge TCLK or negedge TRSTN) begin
      if (!TRSTN) begin
         tap_q  <= TLR;
         ctl_q  <= C_START;
         ir_q   <= 1'b0;
         rs_q   <= 1'b0;
         len_q  <= '0;
         cnt_q  <= '0;
         rcnt_q <= '0;
         sreg_q <= '0;
         rsp_q  <= '0;
         rv_q   <= 1'b0;
         tms_q  <= 1'b1;
         tdi_q  <= 1'b0;
      end else begin
         tap_q  <= tap_d;
         ctl_q  <= ctl_d;
         ir_q   <= ir_d;
         rs_q   <= rs_d;
         len_q  <= len_d;
         cnt_q  <= cnt_d;
         rcnt_q <= rcnt_d;
         sreg_q <= sreg_d;
         rsp_q  <= rsp_d;
         rv_q   <= rv_d;
         tms_q  <= tms_d;
         tdi_q  <= tdi_d;
      end
   end

   assign cmd_ready = ctl_q == C_IDLE;
   assign busy      = ctl_q == C_SCAN;
   assign rsp_valid = rv_q;
   assign rsp_data  = rsp_q;
   assign TMS       = tms_q;
   assign TDI       = tdi_q;

endmodule
